// File: rtl/up_dn_counter_ctrl.sv
// Command-side controller for the 5-bit up/down counter.
// Reaches a requested value by parallel load or single stepping.
module up_dn_counter_ctrl #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 40
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic             Req_Mode,
  input  logic [WIDTH-1:0] Req_Target,
  output logic             Done_Valid,
  output logic             Done_Err,
  output logic [WIDTH-1:0] IN,
  output logic             Load,
  output logic             Up,
  output logic             Down,
  input  logic [WIDTH-1:0] Counter,
  input  logic             High,
  input  logic             Low
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    STEP,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] target_q, target_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             err_q, err_n;

  // Saturation flags only matter as lack of progress; the timeout covers that.
  logic unused_flags;
  assign unused_flags = High ^ Low;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      target_q <= target_n;
      cnt_q    <= cnt_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    target_n   = target_q;
    cnt_n      = cnt_q;
    err_n      = err_q;
    Req_Ready  = 1'b0;
    Done_Valid = 1'b0;
    Done_Err   = 1'b0;
    Load       = 1'b0;
    Up         = 1'b0;
    Down       = 1'b0;
    IN         = target_q;
    unique case (state)
      IDLE: begin
        Req_Ready = 1'b1;
        if (Req_Valid) begin
          target_n = Req_Target;
          cnt_n    = '0;
          state_n  = Req_Mode ? LOAD : STEP;
        end
      end
      LOAD: begin
        Load    = 1'b1;
        state_n = VERIFY;
      end
      VERIFY: begin
        err_n   = (Counter != target_q);
        state_n = DONE;
      end
      STEP: begin
        Up   = (Counter < target_q);
        Down = (Counter > target_q);
        if (Counter == target_q) begin
          err_n   = 1'b0;
          state_n = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE: begin
        Done_Valid = 1'b1;
        Done_Err   = err_q;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
